muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers. It sits beside the ALU in the execute stage of the pipelined MIPS core and generalises the fixed 32-bit multiplier to a parametrised width and radix. It adds signed/unsigned division, direct HI/LO writes (mthi/mtlo), pipeline-flush cancellation and a busy/done handshake that the hazard unit uses for stalls.

Parameters:
WIDTH, 32, operand and HI/LO width in bits; must be even and >= 4.
BITS_PER_CYCLE, 1, quotient/multiplier bits retired per iteration; must divide WIDTH exactly.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request a new operation; sampled only when busy=0.
op  input  2  00 multiply, 01 divide, 10 mthi, 11 mtlo.
sign  input  1  1 means signed (mult/div), 0 means unsigned; ignored for mthi/mtlo.
cancel  input  1  abort the in-flight operation (pipeline flush).
a  input  WIDTH  multiplicand / dividend / mthi-mtlo source.
b  input  WIDTH  multiplier / divisor.
busy  output  1  operation in progress; the core stalls on mfhi/mflo and new mult/div.
done  output  1  one-cycle pulse; HI/LO were updated at this edge.
hi  output  WIDTH  HI register (product high half / remainder).
lo  output  WIDTH  LO register (product low half / quotient).

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, state IDLE. Reset mid-operation discards all work. No done is generated.
- Let N = WIDTH/BITS_PER_CYCLE.
- States: IDLE, RUN, FIX.
  - IDLE -> RUN on start with op[1]=0 and cancel=0.
  - RUN holds for N cycles, then -> FIX.
  - FIX lasts 1 cycle, then -> IDLE.
- IDLE, start and cancel=0, op=1x: on that edge the unit writes a into hi (op=10) or lo (op=11). done=1 the next cycle, busy stays 0, latency 1.
- Mult/div timing: start sampled at edge t. busy=1 in cycles t+1..t+N+1. At edge t+N+2, hi/lo update, busy=0 and done=1 for exactly one cycle. Total latency N+2 (34 for defaults).
- RUN step:
  - Operands are first converted to magnitudes when sign=1.
  - Multiply: shift-add of BITS_PER_CYCLE multiplier bits per cycle into a 2*WIDTH accumulator.
  - Divide: restoring division producing BITS_PER_CYCLE quotient bits per cycle.
- FIX step (sign correction):
  - Multiply: product negated if sign=1 and a[MSB] XOR b[MSB]. Results: hi = product[2W-1:W], lo = product[W-1:0].
  - Divide: quotient negated if the operand signs differ. Remainder takes the sign of the dividend. Results: lo = quotient, hi = remainder (truncating division).
- Divide by zero (b=0), any sign: lo = all ones, hi = a. Same latency N+2.
- Signed overflow (a = most negative, b = -1, sign=1): lo = a, hi = 0.
- Operands a, b, op and sign are captured at start. Input changes while busy have no effect.
- start while busy=1 is ignored. No queueing.
- cancel=1 while busy: the next cycle is IDLE with busy=0 and done=0, and hi/lo keep their pre-operation values.
- cancel=1 in the same cycle as start (IDLE): start is ignored, including mthi/mtlo.
- cancel in the FIX cycle aborts; hi/lo are not written.
- cancel while idle has no effect.
- done and a new accepted start may coincide: start in the done cycle is legal and begins the next operation.
- hi/lo change only on done edges or reset.

Test Plan:
- Unsigned mult: WIDTH=32, a=0xFFFFFFFF, b=2, sign=0 -> done 34 cycles after start; hi=0x00000001, lo=0xFFFFFFFE; busy high exactly 33 cycles.
- Signed mult: a=-3 (0xFFFFFFFD), b=5, sign=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Repeat with BITS_PER_CYCLE=4 -> same result, done 10 cycles after start.
- Signed/unsigned div:
  - a=-7, b=2, sign=1 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - a=0xFFFFFFF9, b=2, sign=0 -> lo=0x7FFFFFFC, hi=0x00000001.
- Corner divides:
  - b=0, a=0x12345678 -> lo=0xFFFFFFFF, hi=0x12345678.
  - a=0x80000000, b=0xFFFFFFFF, sign=1 -> lo=0x80000000, hi=0.
- Cancel: mthi 0xAAAA0000 (done next cycle), then mult 7*9, then cancel at cycle 10 -> busy=0 next cycle, no done, hi=0xAAAA0000 unchanged. A following start with op=11, a=5 -> lo=5 after 1 cycle.
- Back-to-back and reset: start a second mult in the done cycle of the first -> accepted, done 34 cycles later. Assert rst at cycle 20 of an operation -> next cycle busy=0, done=0, hi=lo=0. A start while busy=1 is ignored and produces no extra done.

Source files
------------

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply / divide unit holding the architectural HI/LO pair.
//   Multiply is shift-add, divide is restoring division; both retire
//   BITS_PER_CYCLE bits per RUN cycle, followed by one FIX cycle that applies
//   sign correction and writes HI/LO. mthi/mtlo write HI/LO directly.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start         request an operation (honoured only while idle)
//   op            00 mult, 01 div, 10 mthi, 11 mtlo
//   sign          1 = signed mult/div
//   cancel        abort in-flight operation / suppress a same-cycle start
//   a, b          operands (a is also the mthi/mtlo source)
//   busy          mult/div in progress
//   done          one-cycle pulse after HI/LO were written
//   hi, lo        architectural HI / LO registers
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             sign,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int K     = BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CNT_W-1:0]   r_cnt;

    // Datapath state captured at start (not reset: only meaningful in RUN/FIX)
    logic [2*WIDTH-1:0] r_acc;     // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   r_opnd;    // mult: multiplicand magnitude; div: divisor magnitude
    logic               r_div;
    logic               r_a_neg;
    logic               r_b_neg;
    logic               r_dz;
    logic [WIDTH-1:0]   r_a;

    logic               w_accept;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;

    assign w_accept = (r_state == S_IDLE) && start && !cancel;
    assign w_a_neg  = sign & a[WIDTH-1];
    assign w_b_neg  = sign & b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;

    // ---- RUN stage: one multiply step (K multiplier bits) ----
    logic [WIDTH+K-1:0]   w_partial;
    logic [2*WIDTH+K-1:0] w_mul_wide;
    logic [2*WIDTH-1:0]   w_mul_next;

    // Upper half plus multiplicand*digit cannot exceed WIDTH+K bits, so the
    // carry is kept and shifted down into the accumulator with the low half.
    assign w_partial  = {{K{1'b0}}, r_acc[2*WIDTH-1:WIDTH]}
                      + ((WIDTH+K)'(r_opnd) * (WIDTH+K)'(r_acc[K-1:0]));
    assign w_mul_wide = {w_partial, r_acc[WIDTH-1:0]};
    assign w_mul_next = (2*WIDTH)'(w_mul_wide >> K);

    // ---- RUN stage: K restoring-division steps ----
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH:0]     w_trial;

    always_comb begin
        w_rem   = r_acc[2*WIDTH-1:WIDTH];
        w_quo   = r_acc[WIDTH-1:0];
        w_trial = '0;
        for (int i = 0; i < K; i++) begin
            w_trial = {w_rem, w_quo[WIDTH-1]};
            w_quo   = {w_quo[WIDTH-2:0], 1'b0};
            if (w_trial >= {1'b0, r_opnd}) begin
                w_trial  = w_trial - {1'b0, r_opnd};
                w_quo[0] = 1'b1;
            end
            // remainder stays below the divisor, so it always fits WIDTH bits
            w_rem = w_trial[WIDTH-1:0];
        end
    end

    // ---- FIX stage: sign correction and result selection ----
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_prod    = (r_a_neg ^ r_b_neg) ? -r_acc : r_acc;
    assign w_quo_fix = (r_a_neg ^ r_b_neg) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix = r_a_neg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (r_div) begin
            if (r_dz) begin
                w_res_hi = r_a;
                w_res_lo = '1;
            end else begin
                w_res_hi = w_rem_fix;
                w_res_lo = w_quo_fix;
            end
        end
    end

    // ---- Control FSM and architectural registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (op[1]) begin
                            if (op[0]) r_lo <= a;
                            else       r_hi <= a;
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (cancel) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST) r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (!cancel) begin
                        r_hi   <= w_res_hi;
                        r_lo   <= w_res_lo;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ---- Operand capture and iteration datapath ----
    always_ff @(posedge clk) begin
        if (w_accept && !op[1]) begin
            r_div   <= op[0];
            r_a_neg <= w_a_neg;
            r_b_neg <= w_b_neg;
            r_a     <= a;
            r_dz    <= (b == '0);
            r_acc   <= op[0] ? {{WIDTH{1'b0}}, w_a_mag} : {{WIDTH{1'b0}}, w_b_mag};
            r_opnd  <= op[0] ? w_b_mag : w_a_mag;
        end else if (r_state == S_RUN) begin
            r_acc <= r_div ? {w_rem, w_quo} : w_mul_next;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the stimulus side pushes expected HI/LO
// and the due cycle of each accepted operation; a monitor pops on done.
module tb_muldiv_unit;
    localparam int W   = 32;
    localparam int BPC = 1;
    localparam int N   = W / BPC;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic         sign = 1'b0;
    logic         cancel = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    muldiv_unit #(.WIDTH(W), .BITS_PER_CYCLE(BPC)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .sign(sign),
        .cancel(cancel), .a(a), .b(b), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           due;
        string        name;
    } exp_t;

    exp_t         sbq[$];
    int           busy_until = -1;
    logic [W-1:0] sh_hi = '0;
    logic [W-1:0] sh_lo = '0;
    int           n_chk = 0;
    int           n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain arithmetic on the mathematical values.
    function automatic void model(input logic [1:0] o, input logic sg,
                                  input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] h, output logic [W-1:0] l);
        logic signed [2*W-1:0] sx, sy, sq, sr;
        logic [2*W-1:0]        prod;
        h = sh_hi;
        l = sh_lo;
        sx = sg ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
        sy = sg ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
        case (o)
            2'b00: begin
                prod = sx * sy;
                h = prod[2*W-1:W];
                l = prod[W-1:0];
            end
            2'b01: begin
                if (y == '0) begin
                    h = x;
                    l = '1;
                end else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    h = sr[W-1:0];
                    l = sq[W-1:0];
                end
            end
            2'b10: h = x;
            default: l = x;
        endcase
    endfunction

    // One stimulus cycle, driven at the falling edge.
    task automatic drive(input bit st, input logic [1:0] o, input bit sg,
                         input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit cn, input string name);
        exp_t e;
        @(negedge clk);
        start = st; op = o; sign = sg; a = x; b = y; cancel = cn;
        if (cn && cyc <= busy_until) begin
            if (sbq.size() > 0) void'(sbq.pop_back());
            busy_until = cyc;
        end else if (st && !cn && cyc > busy_until) begin
            model(o, sg, x, y, e.hi, e.lo);
            e.name = name;
            if (o[1]) begin
                e.due = cyc + 1;
            end else begin
                e.due = cyc + N + 2;
                busy_until = cyc + N + 1;
            end
            sbq.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 2'($urandom), 1'($urandom), $urandom, $urandom, 1'b0, "");
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((sbq.size() > 0 || cyc <= busy_until) && k < 4 * N + 20) begin
            idle(1);
            k++;
        end
        check("drain", 64'(sbq.size()), 64'd0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1; start = 1'b0; cancel = 1'b0;
        sbq.delete();
        busy_until = cyc;
        sh_hi = '0;
        sh_lo = '0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
    endtask

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(W-1){1'b0}}};
            3: return W'($urandom_range(0, 9));
            4: return -W'($urandom_range(1, 9));
            default: return W'($urandom);
        endcase
    endfunction

    // Monitor: busy per cycle, HI/LO stability, done against the scoreboard.
    initial begin
        logic [W-1:0] ph, pl;
        exp_t e;
        ph = '0;
        pl = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                check("busy", 64'(busy), 64'(cyc <= busy_until));
                if (done) begin
                    if (sbq.size() == 0) begin
                        check("spurious done", 64'(done), 64'd0);
                    end else begin
                        e = sbq.pop_front();
                        check({e.name, " hi"}, 64'(hi), 64'(e.hi));
                        check({e.name, " lo"}, 64'(lo), 64'(e.lo));
                        check({e.name, " latency"}, 64'(cyc), 64'(e.due));
                        sh_hi = e.hi;
                        sh_lo = e.lo;
                    end
                end else begin
                    check("hi stable", 64'(hi), 64'(ph));
                    check("lo stable", 64'(lo), 64'(pl));
                    if (sbq.size() > 0 && cyc > sbq[0].due) begin
                        e = sbq.pop_front();
                        check({e.name, " done missing"}, 64'(done), 64'd1);
                    end
                end
            end
            ph = hi;
            pl = lo;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(3);

        // Directed arithmetic cases
        drive(1, 2'b00, 0, 32'hFFFF_FFFF, 32'd2, 0, "umul");         wait_drain();
        check("umul hi", 64'(hi), 64'h0000_0001);
        check("umul lo", 64'(lo), 64'hFFFF_FFFE);
        drive(1, 2'b00, 1, 32'hFFFF_FFFD, 32'd5, 0, "smul");         wait_drain();
        check("smul lo", 64'(lo), 64'hFFFF_FFF1);
        drive(1, 2'b01, 1, 32'hFFFF_FFF9, 32'd2, 0, "sdiv");         wait_drain();
        check("sdiv lo", 64'(lo), 64'hFFFF_FFFD);
        check("sdiv hi", 64'(hi), 64'hFFFF_FFFF);
        drive(1, 2'b01, 0, 32'hFFFF_FFF9, 32'd2, 0, "udiv");         wait_drain();
        check("udiv lo", 64'(lo), 64'h7FFF_FFFC);
        drive(1, 2'b01, 0, 32'h1234_5678, 32'd0, 0, "udiv0");        wait_drain();
        check("udiv0 lo", 64'(lo), 64'hFFFF_FFFF);
        check("udiv0 hi", 64'(hi), 64'h1234_5678);
        drive(1, 2'b01, 1, 32'h8765_4321, 32'd0, 0, "sdiv0");        wait_drain();
        drive(1, 2'b01, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "sovf"); wait_drain();
        check("sovf lo", 64'(lo), 64'h8000_0000);
        check("sovf hi", 64'(hi), 64'd0);
        drive(1, 2'b01, 1, 32'd7, 32'hFFFF_FFFE, 0, "sdivnb");       wait_drain();

        // Cancel mid-run, then mtlo
        drive(1, 2'b10, 0, 32'hAAAA_0000, 32'd0, 0, "mthi");         wait_drain();
        drive(1, 2'b00, 0, 32'd7, 32'd9, 0, "mul79");
        idle(9);
        drive(0, 2'b00, 0, 32'd0, 32'd0, 1, "");
        idle(2);
        check("cancel busy", 64'(busy), 64'd0);
        check("cancel hi kept", 64'(hi), 64'hAAAA_0000);
        drive(1, 2'b11, 0, 32'd5, 32'd0, 0, "mtlo");                 wait_drain();
        check("mtlo lo", 64'(lo), 64'd5);

        // Cancel in the FIX cycle, cancel with start, cancel while idle
        drive(1, 2'b00, 1, 32'd123, 32'hFFFF_FF00, 0, "mulfix");
        idle(N);
        drive(0, 2'b00, 0, 32'd0, 32'd0, 1, "");
        wait_drain();
        check("fix cancel hi", 64'(hi), 64'hAAAA_0000);
        drive(1, 2'b10, 0, 32'h1111_2222, 32'd0, 1, "mthi_cn");
        drive(1, 2'b00, 0, 32'd3, 32'd3, 1, "mul_cn");
        drive(0, 2'b00, 0, 32'd0, 32'd0, 1, "");
        idle(3);
        check("cancel-start hi", 64'(hi), 64'hAAAA_0000);

        // Back-to-back: second start in the done cycle of the first
        drive(1, 2'b00, 0, 32'd11, 32'd13, 0, "b2b1");
        idle(N + 1);
        drive(1, 2'b01, 0, 32'd1000, 32'd7, 0, "b2b2");
        wait_drain();

        // Start while busy is ignored
        drive(1, 2'b00, 0, 32'd6, 32'd7, 0, "busy1");
        idle(5);
        drive(1, 2'b01, 0, 32'd99, 32'd3, 0, "ignored");
        wait_drain();

        // Reset in the middle of an operation
        drive(1, 2'b00, 0, 32'hDEAD_BEEF, 32'h1234, 0, "rstmul");
        idle(19);
        do_reset(1);
        idle(3);

        // Randomized traffic
        repeat (300) begin
            idle($urandom_range(0, N + 4));
            drive(1, 2'($urandom), 1'($urandom), rnd_opnd(), rnd_opnd(),
                  ($urandom_range(0, 9) == 0), "rnd");
        end
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
